// File: rtl/seven_seg_pkg.sv
// Shared types and hex-to-segment table for the 7-segment scan controller.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Digit value to segment pattern; bit 4 set blanks the digit.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [4:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        if (!digit[4]) seg = hex_to_seg(digit[3:0]);
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scan scheduler: blank gap, per-slot dimming and double-buffered digits.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [4:0]                    wr_data,
    input  logic [3:0]                    bright,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         dig_sel,
    output logic [6:0]                    seg_oeb,
    output logic                          frame_done
);

    localparam int AW = $clog2(NUM_DIGITS);
    localparam logic [AW:0]      N_EXT      = (AW+1)'(NUM_DIGITS);
    localparam logic [AW-1:0]    LAST_IDX   = AW'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [AW-1:0]    idx, idx_n;
    logic             load, frame_end;

    logic [4:0]       shadow [NUM_DIGITS];
    logic [4:0]       active [NUM_DIGITS];
    logic [3:0]       bright_q;
    logic [6:0]       dec_seg;
    logic [CNT_W:0]   lit_len;
    logic             wr_hit;

    assign wr_hit  = wr_en && ({1'b0, wr_addr} < N_EXT);
    assign lit_len = (CNT_W+1)'((32'(bright_q) + 32'd1) * 32'(DWELL_CYCLES / 16));

    seven_seg_decoder u_dec (
        .digit (active[idx]),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        idx_n     = idx;
        load      = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = BLANK;
                    idx_n   = '0;
                    load    = 1'b1;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DWELL_LAST) begin
                    cnt_n = '0;
                    if (idx == LAST_IDX) begin
                        frame_end = 1'b1;
                        load      = 1'b1;
                        idx_n     = '0;
                        state_n   = enable ? BLANK : IDLE;
                    end else if (enable) begin
                        idx_n   = idx + 1'b1;
                        state_n = BLANK;
                    end else begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Writes in the copy cycle are forwarded so they are not lost for a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 5'h10;
                active[i] <= 5'h10;
            end
            bright_q <= 4'hF;
        end else begin
            if (wr_hit) shadow[wr_addr] <= wr_data;
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= (wr_hit && wr_addr == AW'(i)) ? wr_data : shadow[i];
                end
                bright_q <= bright;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_out    <= 7'h00;
            dig_sel    <= '0;
            seg_oeb    <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            unique case (state)
                BLANK: begin
                    seg_out <= 7'h00;
                    dig_sel <= '0;
                    seg_oeb <= 7'h00;
                end
                DRIVE: begin
                    seg_out <= ({1'b0, cnt} < lit_len) ? dec_seg : 7'h00;
                    dig_sel <= NUM_DIGITS'(1) << idx;
                    seg_oeb <= 7'h00;
                end
                default: begin
                    seg_out <= 7'h00;
                    dig_sel <= '0;
                    seg_oeb <= 7'h7F;
                end
            endcase
        end
    end

endmodule
